// File: rtl/piso_serializer.sv
// Parallel-in serial-out link source: one bit per clk, first bit one cycle after accept, din_ready stalls mid-frame.
// Define PISO_PARITY_EN to append an even-parity bit (frame length WIDTH+1).
module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_start,
   output logic             busy
);

`ifdef PISO_PARITY_EN
   localparam int FLEN = WIDTH + 1;
`else
   localparam int FLEN = WIDTH;
`endif
   localparam int CW = $clog2(FLEN + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
   logic             sout_nxt, sout_valid_nxt, sout_start_nxt;
   logic             last_bit, xfer;
`ifdef PISO_PARITY_EN
   logic             par_bit, par_bit_nxt;
`endif

   function automatic logic head(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // The shift register holds only the bits still to be sent after the one on sout.
   function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   assign last_bit = (bit_cnt == CW'(FLEN - 1));
   assign xfer     = din_valid && din_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (xfer) state_nxt = SHIFT;
         SHIFT:   if (last_bit && !xfer) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      din_ready      = (state == IDLE) || (state == SHIFT && last_bit);
      busy           = (state == SHIFT);
      shreg_nxt      = shreg;
      bit_cnt_nxt    = bit_cnt;
      sout_nxt       = 1'b0;
      sout_valid_nxt = 1'b0;
      sout_start_nxt = 1'b0;
`ifdef PISO_PARITY_EN
      par_bit_nxt    = par_bit;
`endif
      if (xfer) begin
         shreg_nxt      = tail(din);
         bit_cnt_nxt    = '0;
         sout_nxt       = head(din);
         sout_valid_nxt = 1'b1;
         sout_start_nxt = 1'b1;
`ifdef PISO_PARITY_EN
         par_bit_nxt    = ^din;
`endif
      end else if (state == SHIFT && !last_bit) begin
         shreg_nxt      = tail(shreg);
         bit_cnt_nxt    = bit_cnt + CW'(1);
         sout_valid_nxt = 1'b1;
`ifdef PISO_PARITY_EN
         sout_nxt       = (bit_cnt == CW'(WIDTH - 1)) ? par_bit : head(shreg);
`else
         sout_nxt       = head(shreg);
`endif
      end else if (state == SHIFT) begin
         bit_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg      <= '0;
         bit_cnt    <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         sout_start <= 1'b0;
`ifdef PISO_PARITY_EN
         par_bit    <= 1'b0;
`endif
      end else begin
         shreg      <= shreg_nxt;
         bit_cnt    <= bit_cnt_nxt;
         sout       <= sout_nxt;
         sout_valid <= sout_valid_nxt;
         sout_start <= sout_start_nxt;
`ifdef PISO_PARITY_EN
         par_bit    <= par_bit_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed table, hand-written corner sequences and a queue-based random reference.
module tb_piso_serializer;
   localparam int W = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [W-1:0] din = '0;
   logic       din_valid = 1'b0;
   logic       m_ready, m_sout, m_vld, m_start, m_busy;
   logic       l_ready, l_sout, l_vld, l_start, l_busy;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_ready),
      .sout(m_sout), .sout_valid(m_vld), .sout_start(m_start), .busy(m_busy));

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_ready),
      .sout(l_sout), .sout_valid(l_vld), .sout_start(l_start), .busy(l_busy));

   // Reference: a queue of bits still owed on the line; the source may hand over a word only once it is empty.
   typedef struct packed {logic msb; logic lsb; logic start;} item_t;
   typedef struct packed {logic v; logic [W-1:0] d; logic rdy; logic so; logic vl; logic st;} vec_t;

   item_t q[$];
   item_t cur;
   logic  cur_v;
   vec_t  tbl[$];
   int    checks = 0;
   int    failures = 0;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      cur_v = 1'b0;
      cur   = '0;
   endtask

   task automatic model_push(input logic [W-1:0] d);
      for (int k = 0; k < W; k++) begin
         item_t it;
         it.msb   = d[W-1-k];
         it.lsb   = d[k];
         it.start = (k == 0);
         q.push_back(it);
      end
`ifdef PISO_PARITY_EN
      begin
         item_t p;
         p.msb   = ^d;
         p.lsb   = ^d;
         p.start = 1'b0;
         q.push_back(p);
      end
`endif
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_sout"}, m_sout, 1'b0);
      chk({tag, "_valid"}, m_vld, 1'b0);
      chk({tag, "_start"}, m_start, 1'b0);
      chk({tag, "_busy"}, m_busy, 1'b0);
      chk({tag, "_lsb_valid"}, l_vld, 1'b0);
   endtask

   // Called at posedge+1; drives inputs, checks ready, takes one edge, checks outputs.
   task automatic cycle(input logic v, input logic [W-1:0] d);
      logic mrdy;
      din_valid = v;
      din       = d;
      mrdy      = (q.size() == 0);
      chk("din_ready", m_ready, mrdy);
      chk("lsb_din_ready", l_ready, mrdy);
      @(posedge clk);
      if (v && mrdy) model_push(d);
      if (q.size() > 0) begin
         cur   = q.pop_front();
         cur_v = 1'b1;
      end else begin
         cur   = '0;
         cur_v = 1'b0;
      end
      #1;
      chk("sout", m_sout, cur_v & cur.msb);
      chk("sout_valid", m_vld, cur_v);
      chk("sout_start", m_start, cur_v & cur.start);
      chk("busy", m_busy, cur_v);
      chk("lsb_sout", l_sout, cur_v & cur.lsb);
      chk("lsb_sout_valid", l_vld, cur_v);
      chk("lsb_sout_start", l_start, cur_v & cur.start);
   endtask

   task automatic reset_pulse(input string tag);
      din_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs_zero(tag);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic rdy,
                               input logic so, input logic vl, input logic st);
      vec_t r;
      r.v = v; r.d = d; r.rdy = rdy; r.so = so; r.vl = vl; r.st = st;
      return r;
   endfunction

   initial begin
      logic [W-1:0] word;

`ifdef PISO_PARITY_EN
      tbl.push_back(mk(1, 4'b1011, 1, 1, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0));
      tbl.push_back(mk(1, 4'b0110, 1, 0, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0));
`else
      tbl.push_back(mk(1, 4'b1011, 1, 1, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0));
      tbl.push_back(mk(1, 4'b1011, 1, 1, 1, 1));
      tbl.push_back(mk(1, 4'b0110, 0, 0, 1, 0));
      tbl.push_back(mk(1, 4'b0110, 0, 1, 1, 0));
      tbl.push_back(mk(1, 4'b0110, 0, 1, 1, 0));
      tbl.push_back(mk(1, 4'b0110, 1, 0, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0));
      tbl.push_back(mk(1, 4'b1011, 1, 1, 1, 1));
      tbl.push_back(mk(1, 4'b1111, 0, 0, 1, 0));
      tbl.push_back(mk(1, 4'b1111, 0, 1, 1, 0));
      tbl.push_back(mk(1, 4'b1111, 0, 1, 1, 0));
      tbl.push_back(mk(1, 4'b1111, 1, 1, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 0, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 0));
`endif

      model_reset();
      #2;
      check_outputs_zero("reset");
      #10 rst = 1'b0;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         chk("tbl_ready", m_ready, tbl[i].rdy);
         cycle(tbl[i].v, tbl[i].d);
         chk("tbl_sout", m_sout, tbl[i].so);
         chk("tbl_valid", m_vld, tbl[i].vl);
         chk("tbl_start", m_start, tbl[i].st);
      end

      // LSB-first instance sends din[0] first.
      word = 4'b0001;
      for (int k = 0; k < W; k++) begin
         cycle(k == 0, word);
         chk("lsb_first_bit", l_sout, word[k]);
      end
      for (int k = 0; k < 4; k++) cycle(1'b0, '0);

      // Abort after two bits, then the next word must go out whole.
      cycle(1'b1, 4'b1011);
      cycle(1'b0, 4'b0000);
      reset_pulse("midframe_rst");
      word = 4'b0101;
      for (int k = 0; k < W; k++) begin
         cycle(k == 0, word);
         chk("post_rst_sout", m_sout, word[W-1-k]);
         chk("post_rst_start", m_start, k == 0);
      end
      for (int k = 0; k < 4; k++) cycle(1'b0, '0);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 79) == 0) reset_pulse("rand_rst");
         else cycle($urandom_range(0, 3) != 0, W'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
